// File: rtl/beat_clock_gen.sv
// beat_clock_gen: musical timebase for the rhythm game.
// A fractional phase accumulator adds bpm*SUBDIVS every running cycle and wraps
// at 60*CLK_HZ, so the long-run subdivision rate is exact for any BPM.
// Subdivision/eighth/quarter/bar strobes are registered one-cycle pulses.
// A separate free-running down-counter produces the frame tick.
module beat_clock_gen #(
    parameter int CLK_HZ        = 6_300_000,
    parameter int BPM_W         = 9,
    parameter int DEFAULT_BPM   = 60,
    parameter int MIN_BPM       = 20,
    parameter int SUBDIV_LOG2   = 2,
    parameter int BEATS_PER_BAR = 4,
    parameter int TICK_HZ       = 60
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   run_i,
    input  logic                   restart_i,
    input  logic                   bpm_load_i,
    input  logic [BPM_W-1:0]       bpm_i,
    output logic [BPM_W-1:0]       bpm_o,
    output logic                   sub_o,
    output logic                   eighth_o,
    output logic                   quarter_o,
    output logic                   bar_o,
    output logic [SUBDIV_LOG2-1:0] sub_idx_o,
    output logic [((BEATS_PER_BAR > 1) ? $clog2(BEATS_PER_BAR) : 1)-1:0] beat_idx_o,
    output logic                   tick_o
);

    localparam int              BEAT_W   = (BEATS_PER_BAR > 1) ? $clog2(BEATS_PER_BAR) : 1;
    localparam int              SUBDIVS  = 1 << SUBDIV_LOG2;
    localparam int              INC_W    = BPM_W + SUBDIV_LOG2;
    localparam longint unsigned MOD      = 64'(60) * 64'(CLK_HZ);
    localparam longint unsigned MAX_INC  = ((64'(1) << BPM_W) - 64'(1)) << SUBDIV_LOG2;
    localparam int              ACC_W    = $clog2(MOD + MAX_INC + 64'(1));
    localparam int              TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int              TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [ACC_W-1:0]       MOD_V       = ACC_W'(MOD);
    // Low sub-index bits that must be zero for an eighth; empty mask when SUBDIVS==2.
    localparam logic [SUBDIV_LOG2-1:0] EIGHTH_MASK = SUBDIV_LOG2'((SUBDIVS / 2) - 1);
    localparam logic [BEAT_W-1:0]      LAST_BEAT   = BEAT_W'(BEATS_PER_BAR - 1);
    localparam logic [BPM_W-1:0]       MIN_V       = BPM_W'(MIN_BPM);
    localparam logic [BPM_W-1:0]       DEF_V       = BPM_W'(DEFAULT_BPM);
    localparam logic [TICK_W-1:0]      TICK_RELOAD = TICK_W'(TICK_DIV - 1);

    logic [ACC_W-1:0]       r_acc;
    logic [BPM_W-1:0]       r_bpm;
    logic [SUBDIV_LOG2-1:0] r_sub_idx;
    logic [BEAT_W-1:0]      r_beat_idx;
    logic                   r_sub;
    logic                   r_eighth;
    logic                   r_quarter;
    logic                   r_bar;
    logic [TICK_W-1:0]      r_tick_cnt;
    logic                   r_tick;

    logic [INC_W-1:0]       w_inc;
    logic [ACC_W-1:0]       w_nxt;
    logic                   w_wrap;
    logic                   w_event;
    logic [SUBDIV_LOG2-1:0] w_sub_nxt;
    logic [BEAT_W-1:0]      w_beat_nxt;
    logic [BPM_W-1:0]       w_bpm_ld;

    assign w_inc      = {r_bpm, {SUBDIV_LOG2{1'b0}}};
    assign w_nxt      = r_acc + ACC_W'(w_inc);
    assign w_wrap     = (w_nxt >= MOD_V);
    assign w_event    = run_i & ~restart_i & w_wrap;
    assign w_sub_nxt  = r_sub_idx + SUBDIV_LOG2'(1);
    assign w_beat_nxt = (r_beat_idx == LAST_BEAT) ? '0 : r_beat_idx + BEAT_W'(1);
    assign w_bpm_ld   = (bpm_i < MIN_V) ? MIN_V : bpm_i;

    // Phase accumulator: cleared by restart, advances only while running.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_acc <= '0;
        end else if (restart_i) begin
            r_acc <= '0;
        end else if (run_i) begin
            r_acc <= w_wrap ? (w_nxt - MOD_V) : w_nxt;
        end
    end

    // Active BPM; a new value changes the increment but never the phase.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_bpm <= DEF_V;
        end else if (bpm_load_i) begin
            r_bpm <= w_bpm_ld;
        end
    end

    // Position indices and the nested musical strobes, registered together.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sub_idx  <= '0;
            r_beat_idx <= '0;
            r_sub      <= 1'b0;
            r_eighth   <= 1'b0;
            r_quarter  <= 1'b0;
            r_bar      <= 1'b0;
        end else begin
            r_sub     <= 1'b0;
            r_eighth  <= 1'b0;
            r_quarter <= 1'b0;
            r_bar     <= 1'b0;
            if (restart_i) begin
                r_sub_idx  <= '0;
                r_beat_idx <= '0;
                // A running restart lands on a downbeat; a frozen one is silent.
                if (run_i) begin
                    r_sub     <= 1'b1;
                    r_eighth  <= 1'b1;
                    r_quarter <= 1'b1;
                    r_bar     <= 1'b1;
                end
            end else if (w_event) begin
                r_sub_idx <= w_sub_nxt;
                r_sub     <= 1'b1;
                r_eighth  <= ((w_sub_nxt & EIGHTH_MASK) == '0);
                if (w_sub_nxt == '0) begin
                    r_beat_idx <= w_beat_nxt;
                    r_quarter  <= 1'b1;
                    r_bar      <= (w_beat_nxt == '0);
                end
            end
        end
    end

    // Frame tick: free-running down-counter, pulse on terminal count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tick_cnt <= TICK_RELOAD;
            r_tick     <= 1'b0;
        end else if (r_tick_cnt == '0) begin
            r_tick_cnt <= TICK_RELOAD;
            r_tick     <= 1'b1;
        end else begin
            r_tick_cnt <= r_tick_cnt - TICK_W'(1);
            r_tick     <= 1'b0;
        end
    end

    assign bpm_o      = r_bpm;
    assign sub_o      = r_sub;
    assign eighth_o   = r_eighth;
    assign quarter_o  = r_quarter;
    assign bar_o      = r_bar;
    assign sub_idx_o  = r_sub_idx;
    assign beat_idx_o = r_beat_idx;
    assign tick_o     = r_tick;

endmodule

// File: tb/tb_beat_clock_gen.sv
// Directed bench for beat_clock_gen at CLK_HZ=1200 (MOD=72000), TICK_HZ=60.
module tb_beat_clock_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run, restart, load;
    logic [8:0] bpm;
    logic [8:0] bpm_o;
    logic       sub_o, eighth_o, quarter_o, bar_o, tick_o;
    logic [1:0] sub_idx_o, beat_idx_o;

    always #5 clk = ~clk;

    beat_clock_gen #(
        .CLK_HZ(1200), .BPM_W(9), .DEFAULT_BPM(60), .MIN_BPM(20),
        .SUBDIV_LOG2(2), .BEATS_PER_BAR(4), .TICK_HZ(60)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .run_i(run), .restart_i(restart),
        .bpm_load_i(load), .bpm_i(bpm), .bpm_o(bpm_o),
        .sub_o(sub_o), .eighth_o(eighth_o), .quarter_o(quarter_o), .bar_o(bar_o),
        .sub_idx_o(sub_idx_o), .beat_idx_o(beat_idx_o), .tick_o(tick_o)
    );

    typedef struct {
        logic       run;
        logic       restart;
        logic       load;
        logic [8:0] bpm;
        int         n;
        logic       quiet;
        logic       sub, eighth, quarter, bar;
        logic [1:0] sidx, bidx;
        logic [8:0] bpmo;
    } vec_t;

    vec_t vt[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic rs, input logic ld, input int b, input int n,
                       input logic q, input logic s, input logic e, input logic qt, input logic br,
                       input int si, input int bi, input int bo);
        vec_t v;
        v.run = r; v.restart = rs; v.load = ld; v.bpm = 9'(b); v.n = n; v.quiet = q;
        v.sub = s; v.eighth = e; v.quarter = qt; v.bar = br;
        v.sidx = 2'(si); v.bidx = 2'(bi); v.bpmo = 9'(bo);
        vt.push_back(v);
    endtask

    // Drive a vector at a negedge: restart/load last one cycle, run holds for n cycles.
    task automatic apply(input int k);
        vec_t v;
        int   subs_seen;
        v = vt[k];
        subs_seen = 0;
        run = v.run; restart = v.restart; load = v.load; bpm = v.bpm;
        for (int c = 0; c < v.n; c++) begin
            @(negedge clk);
            restart = 1'b0;
            load    = 1'b0;
            if (c < v.n - 1 && sub_o) subs_seen++;
        end
        if (v.quiet) check($sformatf("v%0d early_sub", k), subs_seen, 0);
        check($sformatf("v%0d sub", k),      int'(sub_o),      int'(v.sub));
        check($sformatf("v%0d eighth", k),   int'(eighth_o),   int'(v.eighth));
        check($sformatf("v%0d quarter", k),  int'(quarter_o),  int'(v.quarter));
        check($sformatf("v%0d bar", k),      int'(bar_o),      int'(v.bar));
        check($sformatf("v%0d sub_idx", k),  int'(sub_idx_o),  int'(v.sidx));
        check($sformatf("v%0d beat_idx", k), int'(beat_idx_o), int'(v.bidx));
        check($sformatf("v%0d bpm", k),      int'(bpm_o),      int'(v.bpmo));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " bpm"},      int'(bpm_o),      60);
        check({tag, " sub_idx"},  int'(sub_idx_o),  0);
        check({tag, " beat_idx"}, int'(beat_idx_o), 0);
        check({tag, " strobes"},  int'({sub_o, eighth_o, quarter_o, bar_o}), 0);
        check({tag, " tick"},     int'(tick_o),     0);
    endtask

    // Continuous checks: tick period from reset release, eighth position, strobe nesting.
    int cyc = 0;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            cyc = 0;
            check("tick_in_reset", int'(tick_o), 0);
        end else begin
            cyc++;
            check($sformatf("tick@%0d", cyc), int'(tick_o), int'(cyc % 20 == 0));
            if (eighth_o) check("eighth_pos", int'(sub_idx_o == 2'd0 || sub_idx_o == 2'd2), 1);
            if (bar_o)    check("bar_nest", int'(quarter_o), 1);
            if (quarter_o) check("quarter_nest", int'(eighth_o), 1);
            if (eighth_o) check("eighth_nest", int'(sub_o), 1);
        end
    end

    initial begin
        //   run rs ld bpm   n  q  s e q b si bi bpmo
        // 60 BPM from reset: sub every 300, quarter every 1200, bar every 4800
        add(1, 0, 0, 0,  299, 1, 0,0,0,0, 0, 0, 60);   // 0
        add(1, 0, 0, 0,    1, 1, 1,0,0,0, 1, 0, 60);   // 1
        add(1, 0, 0, 0,  300, 1, 1,1,0,0, 2, 0, 60);   // 2
        add(1, 0, 0, 0,  300, 1, 1,0,0,0, 3, 0, 60);   // 3
        add(1, 0, 0, 0,  300, 1, 1,1,1,0, 0, 1, 60);   // 4
        add(1, 0, 0, 0, 1200, 0, 1,1,1,0, 0, 2, 60);   // 5
        add(1, 0, 0, 0, 1200, 0, 1,1,1,0, 0, 3, 60);   // 6
        add(1, 0, 0, 0, 1200, 0, 1,1,1,1, 0, 0, 60);   // 7
        // pause mid-period, resume with no lost or extra sub
        add(1, 0, 0, 0,  150, 1, 0,0,0,0, 0, 0, 60);   // 8
        add(0, 0, 0, 0,  150, 1, 0,0,0,0, 0, 0, 60);   // 9
        add(1, 0, 0, 0,  149, 1, 0,0,0,0, 0, 0, 60);   // 10
        add(1, 0, 0, 0,    1, 1, 1,0,0,0, 1, 0, 60);   // 11
        // reach sub 3 / beat 2, then restart while running
        add(1, 0, 0, 0, 3000, 0, 1,0,0,0, 3, 2, 60);   // 12
        add(1, 0, 0, 0,  100, 1, 0,0,0,0, 3, 2, 60);   // 13
        add(1, 1, 0, 0,    1, 1, 1,1,1,1, 0, 0, 60);   // 14
        add(1, 0, 0, 0,  299, 1, 0,0,0,0, 0, 0, 60);   // 15
        add(1, 0, 0, 0,    1, 1, 1,0,0,0, 1, 0, 60);   // 16
        add(0, 1, 0, 0,    1, 1, 0,0,0,0, 0, 0, 60);   // 17 silent restart
        // clamp to 20 BPM -> 900 clk period; 120 BPM mid-period
        add(0, 0, 1, 5,    1, 1, 0,0,0,0, 0, 0, 20);   // 18
        add(1, 0, 0, 0,  899, 1, 0,0,0,0, 0, 0, 20);   // 19
        add(1, 0, 0, 0,    1, 1, 1,0,0,0, 1, 0, 20);   // 20
        add(1, 0, 0, 0,  450, 1, 0,0,0,0, 1, 0, 20);   // 21
        add(1, 0, 1, 120,  1, 1, 0,0,0,0, 1, 0, 120);  // 22 acc=36080
        add(1, 0, 0, 0,   74, 1, 0,0,0,0, 1, 0, 120);  // 23 acc=71600
        add(1, 0, 0, 0,    1, 1, 1,1,0,0, 2, 0, 120);  // 24 acc=80
        add(1, 0, 0, 0,  149, 1, 0,0,0,0, 2, 0, 120);  // 25
        add(1, 0, 0, 0,    1, 1, 1,0,0,0, 3, 0, 120);  // 26
        add(1, 0, 0, 0,  150, 1, 1,1,1,0, 0, 1, 120);  // 27
        // restart and load together
        add(1, 1, 1, 60,   1, 1, 1,1,1,1, 0, 0, 60);   // 28
        add(1, 0, 0, 0,  300, 1, 1,0,0,0, 1, 0, 60);   // 29
        // clamp boundaries while frozen
        add(0, 0, 1, 0,    1, 1, 0,0,0,0, 1, 0, 20);   // 30
        add(0, 0, 1, 21,   1, 1, 0,0,0,0, 1, 0, 21);   // 31
        add(0, 0, 1, 60,   1, 1, 0,0,0,0, 1, 0, 60);   // 32

        rst_n = 1'b0; run = 1'b0; restart = 1'b0; load = 1'b0; bpm = '0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");

        rst_n = 1'b1;
        for (int k = 0; k < vt.size(); k++) apply(k);

        // Async reset mid-quarter at a non-default BPM.
        run = 1'b1; load = 1'b1; bpm = 9'd100;
        @(negedge clk);
        load = 1'b0;
        repeat (600) @(negedge clk);
        check("pre_reset bpm", int'(bpm_o), 100);
        #2 rst_n = 1'b0;
        #1 check_reset_state("midreset");
        run = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("held_reset");
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) apply(k);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
